alu_rr_sequencer: RTL

- Shares one 8-bit ALU datapath between two independent requesters (ch0, ch1).
- Uses round-robin arbitration, a valid/ready request handshake per channel, and a registered response with valid/ready.
- Contains the ALU operation decode internally, using the team's standard 4-bit command encoding.
- Sits between two command sources (e.g. a test-vector engine and a host register port) and the downstream result consumer.

---
 rtl/alu_rr_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/alu_rr_sequencer.sv
// Round-robin sequencer sharing one DW-bit ALU between two requesters, with a registered valid/ready response.
// Build option: define ALU_SEQ_ERR_EN to flag DIV-by-zero and SUB borrow on rsp_err.
module alu_rr_sequencer #(
  parameter int DW     = 8,
  parameter int NUM_CH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ch0_valid,
  output logic            ch0_ready,
  input  logic [DW-1:0]   ch0_a,
  input  logic [DW-1:0]   ch0_b,
  input  logic [3:0]      ch0_cmd,
  input  logic            ch1_valid,
  output logic            ch1_ready,
  input  logic [DW-1:0]   ch1_a,
  input  logic [DW-1:0]   ch1_b,
  input  logic [3:0]      ch1_cmd,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2*DW-1:0] rsp_y,
  output logic            rsp_id,
  output logic            rsp_err,
  output logic            busy
);

  // state | meaning
  // IDLE  | arbitrating; granted channel sees ready, operands captured on the edge
  // EXEC  | ALU evaluates captured operands; result registered into rsp_*
  // RESP  | rsp_valid held with stable payload until the consumer takes it

  localparam int RW = 2 * DW;

  localparam logic [3:0] CMD_ADD  = 4'h0;
  localparam logic [3:0] CMD_INC  = 4'h1;
  localparam logic [3:0] CMD_SUB  = 4'h2;
  localparam logic [3:0] CMD_DEC  = 4'h3;
  localparam logic [3:0] CMD_MUL  = 4'h4;
  localparam logic [3:0] CMD_DIV  = 4'h5;
  localparam logic [3:0] CMD_SHL  = 4'h6;
  localparam logic [3:0] CMD_SHR  = 4'h7;
  localparam logic [3:0] CMD_AND  = 4'h8;
  localparam logic [3:0] CMD_OR   = 4'h9;
  localparam logic [3:0] CMD_INV  = 4'hA;
  localparam logic [3:0] CMD_NAND = 4'hB;
  localparam logic [3:0] CMD_NOR  = 4'hC;
  localparam logic [3:0] CMD_XOR  = 4'hD;
  localparam logic [3:0] CMD_XNOR = 4'hE;
  localparam logic [3:0] CMD_BUF  = 4'hF;

  generate
    if (NUM_CH != 2) begin : g_bad_num_ch
      $error("alu_rr_sequencer supports NUM_CH == 2 only");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic            last_grant;
  logic [DW-1:0]   op_a;
  logic [DW-1:0]   op_b;
  logic [3:0]      op_cmd;
  logic            op_id;

  logic            grant_any;
  logic            grant_id;
  logic [DW-1:0]   sel_a;
  logic [DW-1:0]   sel_b;
  logic [3:0]      sel_cmd;

  logic [RW-1:0]   a_x;
  logic [RW-1:0]   b_x;
  logic            shift_oob;
  logic [RW-1:0]   alu_y;

  // Tie goes to the channel that did not win last time.
  always_comb begin
    grant_any = ch0_valid | ch1_valid;
    grant_id  = 1'b0;
    if (ch0_valid && ch1_valid) grant_id = ~last_grant;
    else if (ch1_valid)         grant_id = 1'b1;
  end

  assign ch0_ready = rst_n && (state == IDLE) && grant_any && !grant_id;
  assign ch1_ready = rst_n && (state == IDLE) && grant_any &&  grant_id;

  always_comb begin
    sel_a   = ch0_a;
    sel_b   = ch0_b;
    sel_cmd = ch0_cmd;
    if (grant_id) begin
      sel_a   = ch1_a;
      sel_b   = ch1_b;
      sel_cmd = ch1_cmd;
    end
  end

  always_comb begin
    a_x       = RW'(op_a);
    b_x       = RW'(op_b);
    shift_oob = (32'(op_b) >= 32'(RW));
    alu_y     = a_x;
    case (op_cmd)
      CMD_ADD:  alu_y = a_x + b_x;
      CMD_INC:  alu_y = a_x + RW'(1);
      CMD_SUB:  alu_y = a_x - b_x;
      CMD_DEC:  alu_y = a_x - RW'(1);
      CMD_MUL:  alu_y = a_x * b_x;
      CMD_DIV:  alu_y = (op_b == '0) ? '1 : (a_x / b_x);
      CMD_SHL:  alu_y = shift_oob ? '0 : (a_x << op_b);
      CMD_SHR:  alu_y = shift_oob ? '0 : (a_x >> op_b);
      CMD_AND:  alu_y = a_x & b_x;
      CMD_OR:   alu_y = a_x | b_x;
      CMD_INV:  alu_y = ~a_x;
      CMD_NAND: alu_y = ~(a_x & b_x);
      CMD_NOR:  alu_y = ~(a_x | b_x);
      CMD_XOR:  alu_y = a_x ^ b_x;
      CMD_XNOR: alu_y = ~(a_x ^ b_x);
      CMD_BUF:  alu_y = a_x;
      default:  alu_y = a_x;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_cmd     <= '0;
      op_id      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_y      <= '0;
      rsp_id     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_a       <= sel_a;
            op_b       <= sel_b;
            op_cmd     <= sel_cmd;
            op_id      <= grant_id;
            last_grant <= grant_id;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_y     <= alu_y;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_ERR_EN
  logic alu_err;
  logic rsp_err_q;

  always_comb begin
    alu_err = ((op_cmd == CMD_DIV) && (op_b == '0)) ||
              ((op_cmd == CMD_SUB) && (op_a < op_b));
  end

  // Loaded together with rsp_y so it stays aligned through RESP.
  always_ff @(posedge clk) begin
    if (!rst_n)             rsp_err_q <= 1'b0;
    else if (state == EXEC) rsp_err_q <= alu_err;
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
